// File: rtl/vga_text_pkg.sv
// Shared constants and state encoding for the VGA text buffer
// (used by both the writer and the scan-out side).
package vga_text_pkg;

  localparam int          COLS   = 70;
  localparam int          ROWS   = 30;
  localparam int          CELLS  = COLS * ROWS;
  localparam logic [7:0]  BLANK  = 8'h20;

  localparam logic [7:0]  LF     = 8'h0A;
  localparam logic [7:0]  CR     = 8'h0D;
  localparam logic [7:0]  BS     = 8'h08;
  localparam logic [7:0]  FF     = 8'h0C;

  typedef enum logic [2:0] {
    ST_CLEAR_ALL,
    ST_IDLE,
    ST_PUT,
    ST_SCROLL,
    ST_CLR_ROW
  } state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_text_writer_if.sv
// Byte stream, character RAM port and cursor position of the text writer.
// master = byte source / RAM environment, slave = the writer.
interface vga_text_writer_if;

  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [11:0] rd_addr;
  logic [7:0]  rd_data;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;

  modport master (
    output char_valid, char_data, rd_data,
    input  char_ready, wr_en, wr_addr, wr_data, rd_addr, cursor_x, cursor_y
  );

  modport slave (
    input  char_valid, char_data, rd_data,
    output char_ready, wr_en, wr_addr, wr_data, rd_addr, cursor_x, cursor_y
  );

endinterface

// File: rtl/vga_text_cursor.sv
// Cursor position plus a running row_base = y*COLS, kept without a multiplier.
module vga_text_cursor #(
  parameter int COLS = vga_text_pkg::COLS,
  parameter int ROWS = vga_text_pkg::ROWS
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        inc_i,
  input  logic        newline_i,
  input  logic        cr_i,
  input  logic        back_i,
  input  logic        home_i,
  output logic [6:0]  x_o,
  output logic [4:0]  y_o,
  output logic [11:0] row_base_o,
  output logic        scroll_req_o,
  output logic        at_origin_o
);

  localparam logic [6:0]  LAST_X = 7'(COLS - 1);
  localparam logic [4:0]  LAST_Y = 5'(ROWS - 1);
  localparam logic [11:0] STRIDE = 12'(COLS);

  logic [6:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [11:0] rb_q, rb_d;

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    rb_d = rb_q;
    if (home_i) begin
      x_d  = '0;
      y_d  = '0;
      rb_d = '0;
    end else if (inc_i || newline_i) begin
      if (inc_i && (x_q != LAST_X)) begin
        x_d = x_q + 7'd1;
      end else begin
        x_d = '0;
        // On the last row y stays put; the caller scrolls instead.
        if (y_q != LAST_Y) begin
          y_d  = y_q + 5'd1;
          rb_d = rb_q + STRIDE;
        end
      end
    end else if (cr_i) begin
      x_d = '0;
    end else if (back_i) begin
      if (x_q != '0) begin
        x_d = x_q - 7'd1;
      end else if (y_q != '0) begin
        x_d  = LAST_X;
        y_d  = y_q - 5'd1;
        rb_d = rb_q - STRIDE;
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      x_q  <= '0;
      y_q  <= '0;
      rb_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      rb_q <= rb_d;
    end
  end

  assign x_o          = x_q;
  assign y_o          = y_q;
  assign row_base_o   = rb_q;
  assign at_origin_o  = (x_q == '0) && (y_q == '0);
  assign scroll_req_o = (y_q == LAST_Y) && (newline_i || (inc_i && (x_q == LAST_X)));

endmodule

// File: rtl/vga_text_writer.sv
// Writer side of the VGA text buffer: decodes an ASCII byte stream into
// character RAM writes, with wrap, scroll-up and full-screen clear.
module vga_text_writer #(
  parameter int         COLS  = vga_text_pkg::COLS,
  parameter int         ROWS  = vga_text_pkg::ROWS,
  parameter logic [7:0] BLANK = vga_text_pkg::BLANK
) (
  input  logic             pclk,
  input  logic             reset_n,
  vga_text_writer_if.slave bus
);

  import vga_text_pkg::*;

  localparam logic [11:0] N_CELLS  = 12'(COLS * ROWS);
  localparam logic [11:0] N_COPY   = 12'(COLS * ROWS - COLS);
  localparam logic [11:0] N_COLS   = 12'(COLS);

  state_e      state_q;
  logic [11:0] cnt_q;
  logic        wr_en_q;
  logic [11:0] wr_addr_q;
  logic [7:0]  wr_data_q;
  logic [11:0] rd_addr_q;
  logic        copy_q;
  logic [7:0]  put_data_q;
  logic        adv_q;

  logic        accept;
  logic        cmd_inc, cmd_nl, cmd_cr, cmd_back, cmd_home;
  logic [11:0] row_base;
  logic        scroll_req, at_origin;

  assign accept   = (state_q == ST_IDLE) && bus.char_valid;
  assign cmd_inc  = (state_q == ST_PUT) && adv_q;
  assign cmd_nl   = accept && (bus.char_data == LF);
  assign cmd_cr   = accept && (bus.char_data == CR);
  assign cmd_back = accept && (bus.char_data == BS);
  assign cmd_home = (state_q == ST_CLEAR_ALL) && (cnt_q == N_CELLS);

  vga_text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .pclk        (pclk),
    .reset_n     (reset_n),
    .inc_i       (cmd_inc),
    .newline_i   (cmd_nl),
    .cr_i        (cmd_cr),
    .back_i      (cmd_back),
    .home_i      (cmd_home),
    .x_o         (bus.cursor_x),
    .y_o         (bus.cursor_y),
    .row_base_o  (row_base),
    .scroll_req_o(scroll_req),
    .at_origin_o (at_origin)
  );

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR_ALL;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      copy_q     <= 1'b0;
      put_data_q <= '0;
      adv_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR_ALL: begin
          copy_q <= 1'b0;
          if (cnt_q == N_CELLS) begin
            wr_en_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt_q;
            wr_data_q <= BLANK;
            cnt_q     <= cnt_q + 12'd1;
          end
        end
        ST_IDLE: begin
          wr_en_q <= 1'b0;
          copy_q  <= 1'b0;
          if (accept) begin
            if (is_printable(bus.char_data)) begin
              put_data_q <= bus.char_data;
              adv_q      <= 1'b1;
              state_q    <= ST_PUT;
            end else if (bus.char_data == LF) begin
              if (scroll_req) begin
                cnt_q   <= '0;
                state_q <= ST_SCROLL;
              end
            end else if (bus.char_data == BS) begin
              if (!at_origin) begin
                put_data_q <= BLANK;
                adv_q      <= 1'b0;
                state_q    <= ST_PUT;
              end
            end else if (bus.char_data == FF) begin
              cnt_q   <= '0;
              state_q <= ST_CLEAR_ALL;
            end
          end
        end
        ST_PUT: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= row_base + {5'd0, bus.cursor_x};
          wr_data_q <= put_data_q;
          copy_q    <= 1'b0;
          if (scroll_req) begin
            cnt_q   <= '0;
            state_q <= ST_SCROLL;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SCROLL: begin
          // Read runs one cycle ahead; the write of cell k-1 uses the RAM
          // data returned for the read issued on the previous cycle.
          copy_q    <= 1'b1;
          wr_en_q   <= (cnt_q != '0);
          wr_addr_q <= cnt_q - 12'd1;
          if (cnt_q != N_COPY) begin
            rd_addr_q <= cnt_q + N_COLS;
            cnt_q     <= cnt_q + 12'd1;
          end else begin
            cnt_q   <= '0;
            state_q <= ST_CLR_ROW;
          end
        end
        ST_CLR_ROW: begin
          copy_q <= 1'b0;
          if (cnt_q == N_COLS) begin
            wr_en_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= N_COPY + cnt_q;
            wr_data_q <= BLANK;
            cnt_q     <= cnt_q + 12'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.char_ready = (state_q == ST_IDLE);
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = copy_q ? bus.rd_data : wr_data_q;
  assign bus.rd_addr    = rd_addr_q;

endmodule

// File: tb/tb_vga_text_writer.sv
// Scoreboard bench for vga_text_writer: a screen-level reference model predicts
// every RAM write and the cursor; a monitor pops and compares each DUT write.
module tb_vga_text_writer;

  logic pclk = 1'b0;
  logic reset_n = 1'b0;
  always #5 pclk = ~pclk;

  vga_text_writer_if bus();

  vga_text_writer dut (
    .pclk   (pclk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Character RAM with one-cycle synchronous read
  logic [7:0] ram [0:4095];
  always @(posedge pclk) begin
    if (bus.wr_en) ram[bus.wr_addr] <= bus.wr_data;
    bus.rd_data <= ram[bus.rd_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int addr;
    int data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  logic [7:0] screen [0:2099];
  int cx, cy;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic void push_wr(input int a, input int d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
    screen[a] = 8'(d);
  endfunction

  function automatic void model_clear();
    for (int a = 0; a < 2100; a++) push_wr(a, 32);
    cx = 0;
    cy = 0;
  endfunction

  function automatic void model_scroll();
    for (int r = 0; r < 29; r++)
      for (int c = 0; c < 70; c++)
        push_wr(r * 70 + c, int'(screen[(r + 1) * 70 + c]));
    for (int c = 0; c < 70; c++) push_wr(29 * 70 + c, 32);
  endfunction

  function automatic void model_byte(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      push_wr(cy * 70 + cx, int'(c));
      if (cx < 69) cx++;
      else begin
        cx = 0;
        if (cy < 29) cy++;
        else model_scroll();
      end
    end else begin
      case (c)
        8'h0D: cx = 0;
        8'h0A: begin
          cx = 0;
          if (cy < 29) cy++;
          else model_scroll();
        end
        8'h08: begin
          if (cx > 0) begin
            cx--;
            push_wr(cy * 70 + cx, 32);
          end else if (cy > 0) begin
            cx = 69;
            cy--;
            push_wr(cy * 70 + cx, 32);
          end
        end
        8'h0C: model_clear();
        default: ;
      endcase
    end
  endfunction

  // Monitor: every DUT write must match the oldest predicted write
  initial begin
    forever begin
      @(negedge pclk);
      if (reset_n && bus.wr_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h, no write expected", bus.wr_addr, bus.wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", int'(bus.wr_addr), mon_e.addr);
          chk("wr_data", int'(bus.wr_data), mon_e.data);
        end
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 6000; i++) begin
      @(negedge pclk);
      if (bus.char_ready) break;
    end
    chk("char_ready", int'(bus.char_ready), 1);
  endtask

  task automatic send(input logic [7:0] c);
    bit got;
    got = 1'b0;
    @(negedge pclk);
    bus.char_data  = c;
    bus.char_valid = 1'b1;
    for (int i = 0; i < 6000 && !got; i++) begin
      if (bus.char_ready) got = 1'b1;
      @(posedge pclk);
      if (!got) @(negedge pclk);
    end
    chk("accepted", int'(got), 1);
    if (got) model_byte(c);
  endtask

  task automatic settle();
    @(negedge pclk);
    bus.char_valid = 1'b0;
    wait_ready();
    @(negedge pclk);
    chk("pending_writes", exp_q.size(), 0);
    chk("cursor_x", int'(bus.cursor_x), cx);
    chk("cursor_y", int'(bus.cursor_y), cy);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] odd [6];
  int r;

  initial begin
    odd = '{8'h00, 8'h7F, 8'h1B, 8'h09, 8'hFF, 8'h80};
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    for (int a = 0; a < 4096; a++) ram[a] = 8'h00;
    for (int a = 0; a < 2100; a++) screen[a] = 8'h00;
    cx = 0;
    cy = 0;

    repeat (3) @(negedge pclk);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_wr_addr", int'(bus.wr_addr), 0);
    chk("rst_wr_data", int'(bus.wr_data), 0);
    chk("rst_rd_addr", int'(bus.rd_addr), 0);
    chk("rst_char_ready", int'(bus.char_ready), 0);
    chk("rst_cursor", int'({bus.cursor_x, bus.cursor_y}), 0);

    model_clear();
    reset_n = 1'b1;
    settle();
    chk("ram_last_blank", int'(ram[2099]), 32);

    send(8'h41); settle();

    send(8'h0D); settle();
    send(8'h0A); settle();
    send(8'h0A); settle();
    repeat (69) begin
      send(8'($urandom_range(32, 126)));
      settle();
    end
    chk("pre_z_x", int'(bus.cursor_x), 69);
    send(8'h5A); settle();
    chk("ram_209", int'(ram[209]), 8'h5A);

    send(8'h0C); settle();
    send(8'h0A); settle();
    send(8'h08); settle();
    send(8'h0D); settle();
    send(8'h08); settle();

    repeat (29) begin
      send(8'h0A);
      settle();
    end
    repeat (5) begin
      send(8'($urandom_range(32, 126)));
      settle();
    end
    @(negedge pclk);
    for (int a = 0; a < 2100; a++) begin
      ram[a]    = 8'(8'h30 + a / 70);
      screen[a] = 8'(8'h30 + a / 70);
    end
    send(8'h0A); settle();
    chk("row0_after_scroll", int'(ram[0]), 8'h31);
    chk("row28_after_scroll", int'(ram[28 * 70 + 69]), 8'h4D);
    chk("row29_after_scroll", int'(ram[2099]), 8'h20);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 80)      send(8'($urandom_range(32, 126)));
      else if (r < 86) send(8'h08);
      else if (r < 90) send(8'h0D);
      else if (r < 94) send(8'h0A);
      else             send(odd[$urandom_range(0, 5)]);
      settle();
    end

    send(8'h0C);
    send(8'h42);
    settle();
    chk("ram_0_after_ff", int'(ram[0]), 8'h42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
